n1_sbus_rrarb: RTL
==================

Name: n1_sbus_rrarb

Overview:
- Three-way round-robin arbiter for the N1 merged stack bus (pipelined Wishbone).
- Shares the bus between three initiators:
  - the parameter stack (PS),
  - the return stack (RS),
  - a debug/DMA port (DBG).
- Tags each access with its source and routes responses back to the owner only.
- Limits bus tenure with a burst cap, so a busy stack cannot starve the other two.

Parameters:
SP_WIDTH, 12, stack address width
MAX_BURST, 8, accepted strobes per tenure before the owner is throttled while another initiator waits (1..255)

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active-low
sbus_cyc_o  out  1  merged bus cycle indicator
sbus_stb_o  out  1  merged bus strobe
sbus_we_o  out  1  write enable
sbus_adr_o  out  SP_WIDTH  address
sbus_dat_o  out  16  write data
sbus_tga_ps_o  out  1  parameter stack access tag
sbus_tga_rs_o  out  1  return stack access tag
sbus_tga_dbg_o  out  1  debug access tag
sbus_ack_i / sbus_err_i / sbus_rty_i / sbus_stall_i  in  1 each  target responses
sbus_dat_i  in  16  read data
<x>_cyc_i, <x>_stb_i, <x>_we_i  in  1 each  initiator x in {ps, rs, dbg}
<x>_adr_i  in  SP_WIDTH  initiator x address
<x>_dat_i  in  16  initiator x write data
<x>_ack_o, <x>_err_o, <x>_rty_o, <x>_stall_o  out  1 each  responses to initiator x
<x>_dat_o  out  16  read data to initiator x
prb_state_o  out  2  FSM state (0 IDLE, 1 PS, 2 RS, 3 DBG)
prb_burst_o  out  8  accepted strobe count of the current tenure

Behaviour:
- FSM states: IDLE, OWN_PS, OWN_RS, OWN_DBG. All state is registered; all outputs are combinational from state plus inputs.
- Reset (sync_rst_i=0 at a clock edge) takes effect at that edge:
  - state←IDLE, last_owner←DBG (so PS has first priority), burst_cnt←0, outstanding←0.
  - Resulting outputs: sbus_cyc/stb/we/tga all 0; adr/dat 0; all ack/err/rty 0; all <x>_stall_o=1.
- Request definition: request_x = x_cyc_i.
- Arbitration: evaluated in IDLE, and in OWN_y in the cycle y_cyc_i=0.
  - Round-robin search starts at the successor of last_owner, order PS→RS→DBG→PS.
  - The winner's state is entered at the next edge. With no request, the FSM goes to IDLE.
  - Handoff between owners costs no idle cycle. A requester is stalled for at least the arbitration cycle, so grant latency is 1 cycle.
- While in OWN_x:
  - sbus_cyc_o = x_cyc_i.
  - sbus_stb_o = x_stb_i & ~throttle. we/adr/dat come from x.
  - tga_x=1; the other tags are 0.
  - x_stall_o = sbus_stall_i | throttle. Non-owners' stall=1.
  - x_ack/err/rty = sbus_*_i. Non-owners receive 0.
- sbus_dat_i is broadcast to all <x>_dat_o.
- In IDLE: sbus_adr_o and sbus_dat_o=0, cyc/stb=0.
- Counters:
  - burst_cnt increments on every accepted strobe (sbus_stb_o & ~sbus_stall_i) and saturates at 255. It is cleared on every ownership change.
  - outstanding (4 bits) counts +1 per accepted strobe and −1 per ack|err|rty. Simultaneous accept and response leave it unchanged.
- throttle = (burst_cnt ≥ MAX_BURST) & (another initiator's cyc_i=1).
  - Throttling only blocks new strobes; it never drops sbus_cyc_o.
  - The owner is expected to drain its acks and drop cyc.
- Owner drops cyc with outstanding≠0 (protocol violation):
  - ownership is released anyway and outstanding is cleared;
  - late responses in the following cycle go to the new owner's port only if the new owner is active. This is documented as undefined and not checked.
- last_owner updates on entry to each OWN state.
- Simultaneous requests from all three in IDLE: winner is the successor of last_owner.
- Reset asserted mid-tenure: next cycle sbus_cyc_o=0, regardless of initiator signals.

Test Plan:
1. Reset, then ps_cyc=stb=1 at cycle 0 → ps_stall_o=1 in cycle 0; at cycle 1 prb_state=1, sbus_stb_o=1, tga_ps=1, ps_stall_o=sbus_stall_i.
2. All three request from IDLE after reset → grant order PS, RS, DBG across three tenures. Each owner drops cyc after 2 acks; handoff shows no IDLE cycle.
3. MAX_BURST=8, PS streams continuously, RS requests at PS strobe 3 → exactly 8 sbus strobes accepted. Then ps_stall_o=1 and sbus_stb_o=0 with cyc held. After PS drops cyc, RS owns at the next edge.
4. PS owns alone with 20 strobes and no competitor → no throttle; prb_burst_o=20; no stalls beyond sbus_stall_i.
5. RS owns with sbus_err_i=1 on its 2nd access → rs_err_o=1 for that cycle only; ps_err_o=dbg_err_o=0; outstanding decrements.
6. sync_rst_i=0 during a DBG tenure with 3 outstanding → next cycle: state IDLE, sbus_cyc_o=0, all stalls=1, prb_burst_o=0.

Source files
------------

// File: rtl/n1_sbus_rrarb_if.sv
// N1 merged stack bus: arbiter-side signal bundle.
// Three initiator ports (ps, rs, dbg) and one pipelined Wishbone target port.
interface n1_sbus_rrarb_if #(
  parameter int SP_WIDTH = 12
);
  logic                sbus_cyc_o;
  logic                sbus_stb_o;
  logic                sbus_we_o;
  logic [SP_WIDTH-1:0] sbus_adr_o;
  logic [15:0]         sbus_dat_o;
  logic                sbus_tga_ps_o;
  logic                sbus_tga_rs_o;
  logic                sbus_tga_dbg_o;
  logic                sbus_ack_i;
  logic                sbus_err_i;
  logic                sbus_rty_i;
  logic                sbus_stall_i;
  logic [15:0]         sbus_dat_i;

  logic                ps_cyc_i;
  logic                ps_stb_i;
  logic                ps_we_i;
  logic [SP_WIDTH-1:0] ps_adr_i;
  logic [15:0]         ps_dat_i;
  logic                ps_ack_o;
  logic                ps_err_o;
  logic                ps_rty_o;
  logic                ps_stall_o;
  logic [15:0]         ps_dat_o;

  logic                rs_cyc_i;
  logic                rs_stb_i;
  logic                rs_we_i;
  logic [SP_WIDTH-1:0] rs_adr_i;
  logic [15:0]         rs_dat_i;
  logic                rs_ack_o;
  logic                rs_err_o;
  logic                rs_rty_o;
  logic                rs_stall_o;
  logic [15:0]         rs_dat_o;

  logic                dbg_cyc_i;
  logic                dbg_stb_i;
  logic                dbg_we_i;
  logic [SP_WIDTH-1:0] dbg_adr_i;
  logic [15:0]         dbg_dat_i;
  logic                dbg_ack_o;
  logic                dbg_err_o;
  logic                dbg_rty_o;
  logic                dbg_stall_o;
  logic [15:0]         dbg_dat_o;

  modport master (
    output sbus_cyc_o, sbus_stb_o, sbus_we_o,
    output sbus_adr_o, sbus_dat_o,
    output sbus_tga_ps_o, sbus_tga_rs_o,
    output sbus_tga_dbg_o,
    input  sbus_ack_i, sbus_err_i, sbus_rty_i,
    input  sbus_stall_i, sbus_dat_i,
    input  ps_cyc_i, ps_stb_i, ps_we_i,
    input  ps_adr_i, ps_dat_i,
    output ps_ack_o, ps_err_o, ps_rty_o,
    output ps_stall_o, ps_dat_o,
    input  rs_cyc_i, rs_stb_i, rs_we_i,
    input  rs_adr_i, rs_dat_i,
    output rs_ack_o, rs_err_o, rs_rty_o,
    output rs_stall_o, rs_dat_o,
    input  dbg_cyc_i, dbg_stb_i, dbg_we_i,
    input  dbg_adr_i, dbg_dat_i,
    output dbg_ack_o, dbg_err_o, dbg_rty_o,
    output dbg_stall_o, dbg_dat_o
  );

  modport slave (
    input  sbus_cyc_o, sbus_stb_o, sbus_we_o,
    input  sbus_adr_o, sbus_dat_o,
    input  sbus_tga_ps_o, sbus_tga_rs_o,
    input  sbus_tga_dbg_o,
    output sbus_ack_i, sbus_err_i, sbus_rty_i,
    output sbus_stall_i, sbus_dat_i,
    output ps_cyc_i, ps_stb_i, ps_we_i,
    output ps_adr_i, ps_dat_i,
    input  ps_ack_o, ps_err_o, ps_rty_o,
    input  ps_stall_o, ps_dat_o,
    output rs_cyc_i, rs_stb_i, rs_we_i,
    output rs_adr_i, rs_dat_i,
    input  rs_ack_o, rs_err_o, rs_rty_o,
    input  rs_stall_o, rs_dat_o,
    output dbg_cyc_i, dbg_stb_i, dbg_we_i,
    output dbg_adr_i, dbg_dat_i,
    input  dbg_ack_o, dbg_err_o, dbg_rty_o,
    input  dbg_stall_o, dbg_dat_o
  );
endinterface

// File: rtl/n1_sbus_rrarb.sv
// Three-way round-robin arbiter for the N1 merged stack bus.
// Burst cap throttles the owner's strobes while another initiator waits.
module n1_sbus_rrarb #(
  parameter int SP_WIDTH  = 12,
  parameter int MAX_BURST = 8
) (
  input  logic       clk_i,
  input  logic       sync_rst_i,
  n1_sbus_rrarb_if.master bus,
  output logic [1:0] prb_state_o,
  output logic [7:0] prb_burst_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_PS  = 2'd1,
    OWN_RS  = 2'd2,
    OWN_DBG = 2'd3
  } state_t;

  state_t state_q, state_d, last_q, win;
  logic [7:0] burst_q, burst_d;
  logic [3:0] outst_q, outst_d;

  logic                own_cyc;
  logic                own_stb;
  logic                own_we;
  logic [SP_WIDTH-1:0] own_adr;
  logic [15:0]         own_dat;
  logic                other_req;
  logic                throttle;
  logic                accept;
  logic                resp;
  logic                arb;
  logic                is_ps, is_rs, is_dbg;

  assign is_ps  = (state_q == OWN_PS);
  assign is_rs  = (state_q == OWN_RS);
  assign is_dbg = (state_q == OWN_DBG);

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_dat   = '0;
    other_req = 1'b0;
    unique case (1'b1)
      is_ps: begin
        own_cyc   = bus.ps_cyc_i;
        own_stb   = bus.ps_stb_i;
        own_we    = bus.ps_we_i;
        own_adr   = bus.ps_adr_i;
        own_dat   = bus.ps_dat_i;
        other_req = bus.rs_cyc_i | bus.dbg_cyc_i;
      end
      is_rs: begin
        own_cyc   = bus.rs_cyc_i;
        own_stb   = bus.rs_stb_i;
        own_we    = bus.rs_we_i;
        own_adr   = bus.rs_adr_i;
        own_dat   = bus.rs_dat_i;
        other_req = bus.ps_cyc_i | bus.dbg_cyc_i;
      end
      is_dbg: begin
        own_cyc   = bus.dbg_cyc_i;
        own_stb   = bus.dbg_stb_i;
        own_we    = bus.dbg_we_i;
        own_adr   = bus.dbg_adr_i;
        own_dat   = bus.dbg_dat_i;
        other_req = bus.ps_cyc_i | bus.rs_cyc_i;
      end
      default: ;
    endcase
  end

  // Search starts at the successor of the last owner.
  always_comb begin
    win = IDLE;
    unique case (last_q)
      OWN_PS: begin
        if (bus.rs_cyc_i)       win = OWN_RS;
        else if (bus.dbg_cyc_i) win = OWN_DBG;
        else if (bus.ps_cyc_i)  win = OWN_PS;
      end
      OWN_RS: begin
        if (bus.dbg_cyc_i)      win = OWN_DBG;
        else if (bus.ps_cyc_i)  win = OWN_PS;
        else if (bus.rs_cyc_i)  win = OWN_RS;
      end
      default: begin
        if (bus.ps_cyc_i)       win = OWN_PS;
        else if (bus.rs_cyc_i)  win = OWN_RS;
        else if (bus.dbg_cyc_i) win = OWN_DBG;
      end
    endcase
  end

  assign throttle = (burst_q >= 8'(MAX_BURST)) & other_req;
  assign arb      = (state_q == IDLE) | ~own_cyc;
  assign state_d  = arb ? win : state_q;

  assign bus.sbus_cyc_o     = own_cyc;
  assign bus.sbus_stb_o     = own_cyc & own_stb & ~throttle;
  assign bus.sbus_we_o      = own_we;
  assign bus.sbus_adr_o     = own_adr;
  assign bus.sbus_dat_o     = own_dat;
  assign bus.sbus_tga_ps_o  = is_ps;
  assign bus.sbus_tga_rs_o  = is_rs;
  assign bus.sbus_tga_dbg_o = is_dbg;

  assign bus.ps_stall_o  = is_ps ? (bus.sbus_stall_i | throttle) : 1'b1;
  assign bus.rs_stall_o  = is_rs ? (bus.sbus_stall_i | throttle) : 1'b1;
  assign bus.dbg_stall_o = is_dbg ? (bus.sbus_stall_i | throttle) : 1'b1;

  assign bus.ps_ack_o  = is_ps & bus.sbus_ack_i;
  assign bus.ps_err_o  = is_ps & bus.sbus_err_i;
  assign bus.ps_rty_o  = is_ps & bus.sbus_rty_i;
  assign bus.rs_ack_o  = is_rs & bus.sbus_ack_i;
  assign bus.rs_err_o  = is_rs & bus.sbus_err_i;
  assign bus.rs_rty_o  = is_rs & bus.sbus_rty_i;
  assign bus.dbg_ack_o = is_dbg & bus.sbus_ack_i;
  assign bus.dbg_err_o = is_dbg & bus.sbus_err_i;
  assign bus.dbg_rty_o = is_dbg & bus.sbus_rty_i;

  assign bus.ps_dat_o  = bus.sbus_dat_i;
  assign bus.rs_dat_o  = bus.sbus_dat_i;
  assign bus.dbg_dat_o = bus.sbus_dat_i;

  assign accept = bus.sbus_stb_o & ~bus.sbus_stall_i;
  assign resp   = bus.sbus_ack_i | bus.sbus_err_i
                | bus.sbus_rty_i;

  // Ownership change wipes both counters, even with acks still owed.
  always_comb begin
    burst_d = burst_q;
    outst_d = outst_q;
    if (state_d != state_q) begin
      burst_d = '0;
      outst_d = '0;
    end else begin
      if (accept && burst_q != 8'hff)
        burst_d = burst_q + 8'd1;
      if (accept && !resp)
        outst_d = outst_q + 4'd1;
      else if (!accept && resp && outst_q != '0)
        outst_d = outst_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      state_q <= IDLE;
      last_q  <= OWN_DBG;
      burst_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      outst_q <= outst_d;
      if (state_d != IDLE && state_d != state_q)
        last_q <= state_d;
    end
  end

  assign prb_state_o = state_q;
  assign prb_burst_o = burst_q;

endmodule
